// File: rtl/mem_arbiter_if.sv
// Bundles both cache ports and the memory command/response bus of the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          p0_strobe;
    logic          p0_rw;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ready;
    logic [DW-1:0] p0_rdata;

    logic          p1_strobe;
    logic          p1_rw;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ready;
    logic [DW-1:0] p1_rdata;

    logic          m_strobe;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;
    logic          grant;

    // Arbiter side: accepts port requests, drives the memory.
    modport slave (
        input  p0_strobe, p0_rw, p0_addr, p0_wdata,
        input  p1_strobe, p1_rw, p1_addr, p1_wdata,
        input  m_rdata,
        output p0_ready, p0_rdata, p1_ready, p1_rdata,
        output m_strobe, m_rw, m_addr, m_wdata,
        output busy, grant
    );

    // Requester/memory side.
    modport master (
        output p0_strobe, p0_rw, p0_addr, p0_wdata,
        output p1_strobe, p1_rw, p1_addr, p1_wdata,
        output m_rdata,
        input  p0_ready, p0_rdata, p1_ready, p1_rdata,
        input  m_strobe, m_rw, m_addr, m_wdata,
        input  busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter onto a fixed-wait-state memory; strobe in IDLE cycle n gives ready in n+2+WAIT.
// Requests are held by the ports and only sampled in IDLE, so a loser simply waits for the next IDLE.
module mem_arbiter #(
    parameter int AW   = 16,
    parameter int DW   = 32,
    parameter int WAIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_CNT = 8'(WAIT);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_cnt;
    logic          r_grant;
    logic          w_winner;
    logic          w_start;
    logic          w_last_wait;

    logic          r_m_rw;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic [DW-1:0] r_p0_rdata;
    logic [DW-1:0] r_p1_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == 8'd1);

    // On a tie the port that did not win last time goes first.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_winner     = r_grant;
        case (r_state)
            S_IDLE: begin
                if (bus.p0_strobe || bus.p1_strobe) begin
                    w_start      = 1'b1;
                    w_next_state = S_ISSUE;
                    if (bus.p0_strobe && bus.p1_strobe) begin
                        w_winner = ~r_grant;
                    end else begin
                        w_winner = bus.p1_strobe;
                    end
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_cnt == 8'd1) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= WAIT_CNT;
        end else if (r_state == S_WAIT && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant   <= 1'b1;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_start) begin
            r_grant   <= w_winner;
            r_m_rw    <= w_winner ? bus.p1_rw    : bus.p0_rw;
            r_m_addr  <= w_winner ? bus.p1_addr  : bus.p0_addr;
            r_m_wdata <= w_winner ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    // Memory data is only valid in the final wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if (w_last_wait && !r_m_rw) begin
            if (r_grant) begin
                r_p1_rdata <= bus.m_rdata;
            end else begin
                r_p0_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.m_strobe = (r_state == S_ISSUE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.p0_ready = (r_state == S_DONE) && !r_grant;
    assign bus.p1_ready = (r_state == S_DONE) &&  r_grant;
    assign bus.grant    = r_grant;
    assign bus.m_rw     = r_m_rw;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.p0_rdata = r_p0_rdata;
    assign bus.p1_rdata = r_p1_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-exact hand sequences plus a vector table checked through a completion scoreboard.
module tb_mem_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          en0;
        bit          en1;
        bit          rw0;
        bit          rw1;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          first;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   auto_mem = 1'b1;
    int   since    = 255;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.p0_strobe = 1'b0;
        bus.p1_strobe = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Memory model: read data is valid only in the last wait cycle, garbage otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_strobe) since = 0;
            else if (since < 255) since = since + 1;
            if (auto_mem) bus.m_rdata = (since == WAIT) ? memf(bus.m_addr) : (32'hBAD0_0000 | 32'(since));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[9];
        vec_t        v;
        exp_t        e;
        bit          order[2];
        bit          p;
        int          n, issued, served;
        logic [31:0] exp_rd0, exp_rd1;

        vecs = '{
            '{1, 1, 0, 0, 16'h0100, 16'h0200, 32'h0,        32'h0,        1'b0},
            '{1, 1, 1, 0, 16'h0104, 16'h0204, 32'h11111111, 32'h0,        1'b0},
            '{0, 1, 0, 1, 16'h0000, 16'h0300, 32'h0,        32'h22222222, 1'b1},
            '{1, 1, 0, 1, 16'h0108, 16'h0304, 32'h0,        32'h33333333, 1'b0},
            '{1, 0, 0, 0, 16'h010C, 16'h0000, 32'h0,        32'h0,        1'b0},
            '{1, 1, 1, 0, 16'h0110, 16'h0208, 32'h44444444, 32'h0,        1'b1},
            '{1, 1, 0, 0, 16'h0114, 16'h020C, 32'h0,        32'h0,        1'b1},
            '{0, 1, 0, 0, 16'h0000, 16'h0210, 32'h0,        32'h0,        1'b1},
            '{1, 1, 0, 0, 16'h0118, 16'h0214, 32'h0,        32'h0,        1'b0}
        };

        bus.p0_strobe = 1'b0; bus.p0_rw = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_strobe = 1'b0; bus.p1_rw = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.m_rdata   = '0;

        // Reset values, then a single port-0 read with memory data only in cycle 5.
        do_reset();
        chk1("rst_m_strobe", bus.m_strobe, 1'b0);
        chk1("rst_p0_ready", bus.p0_ready, 1'b0);
        chk1("rst_p1_ready", bus.p1_ready, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_grant", bus.grant, 1'b1);
        chk1("rst_m_rw", bus.m_rw, 1'b0);
        chk("rst_m_addr", 64'(bus.m_addr), 64'h0);
        chk("rst_m_wdata", 64'(bus.m_wdata), 64'h0);
        chk("rst_p0_rdata", 64'(bus.p0_rdata), 64'h0);
        chk("rst_p1_rdata", 64'(bus.p1_rdata), 64'h0);

        auto_mem      = 1'b0;
        bus.m_rdata   = '0;
        bus.p0_strobe = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 16'h0040;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.m_rdata = (c == 5) ? 32'hDEADBEEF : 32'h0;
            chk1("h1_m_strobe", bus.m_strobe, c == 1);
            chk1("h1_busy", bus.busy, c >= 1 && c <= 6);
            chk1("h1_p0_ready", bus.p0_ready, c == 6);
            chk1("h1_p1_ready", bus.p1_ready, 1'b0);
            if (c == 1) begin
                chk("h1_m_addr", 64'(bus.m_addr), 64'h0040);
                chk1("h1_m_rw", bus.m_rw, 1'b0);
            end
            if (c == 6) begin
                chk("h1_p0_rdata", 64'(bus.p0_rdata), 64'hDEADBEEF);
                bus.p0_strobe = 1'b0;
            end
        end
        auto_mem = 1'b1;

        // Simultaneous requests right after reset: port 0 first, port 1 follows.
        do_reset();
        bus.p0_strobe = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 16'h0050;
        bus.p1_strobe = 1'b1; bus.p1_rw = 1'b0; bus.p1_addr = 16'h0060;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk1("h2_m_strobe", bus.m_strobe, c == 1 || c == 8);
            chk1("h2_p0_ready", bus.p0_ready, c == 6);
            chk1("h2_p1_ready", bus.p1_ready, c == 13);
            if (c == 6) begin
                chk("h2_p0_rdata", 64'(bus.p0_rdata), 64'(memf(16'h0050)));
                bus.p0_strobe = 1'b0;
            end
            if (c == 8) begin
                chk1("h2_grant", bus.grant, 1'b1);
                chk("h2_m_addr", 64'(bus.m_addr), 64'h0060);
            end
            if (c == 13) begin
                chk("h2_p1_rdata", 64'(bus.p1_rdata), 64'(memf(16'h0060)));
                bus.p1_strobe = 1'b0;
            end
        end

        // Port 1 write: command stable through wait, read data untouched.
        bus.p1_strobe = 1'b1; bus.p1_rw = 1'b1; bus.p1_addr = 16'h1234; bus.p1_wdata = 32'hA5A5A5A5;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 5) begin
                chk1("h3_m_rw", bus.m_rw, 1'b1);
                chk("h3_m_addr", 64'(bus.m_addr), 64'h1234);
                chk("h3_m_wdata", 64'(bus.m_wdata), 64'hA5A5A5A5);
            end
            chk1("h3_p1_ready", bus.p1_ready, c == 6);
            chk1("h3_p0_ready", bus.p0_ready, 1'b0);
            if (c == 6) begin
                chk("h3_p1_rdata", 64'(bus.p1_rdata), 64'(memf(16'h0060)));
                bus.p1_strobe = 1'b0;
            end
        end

        // Reset in the middle of a read aborts it silently; a later request runs normally.
        do_reset();
        bus.p0_strobe = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 16'h0070;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) begin
                reset         = 1'b1;
                bus.p0_strobe = 1'b0;
            end
            if (c == 4) begin
                reset = 1'b0;
                chk1("h4_grant_rst", bus.grant, 1'b1);
                chk("h4_m_addr_rst", 64'(bus.m_addr), 64'h0);
            end
            if (c == 5) begin
                bus.p0_strobe = 1'b1; bus.p0_addr = 16'h0074;
            end
            chk1("h4_busy", bus.busy, (c >= 1 && c <= 3) || (c >= 6 && c <= 11));
            chk1("h4_m_strobe", bus.m_strobe, c == 1 || c == 6);
            chk1("h4_p0_ready", bus.p0_ready, c == 11);
            chk1("h4_p1_ready", bus.p1_ready, 1'b0);
            if (c == 11) begin
                chk("h4_p0_rdata", 64'(bus.p0_rdata), 64'(memf(16'h0074)));
                bus.p0_strobe = 1'b0;
            end
        end

        // Vector table: completion order and returned data via scoreboard.
        do_reset();
        exp_rd0 = '0;
        exp_rd1 = '0;
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            if (v.en0 && v.en1) begin
                order[0] = v.first; order[1] = !v.first; n = 2;
            end else begin
                order[0] = v.en1; order[1] = 1'b0; n = 1;
            end
            for (int k = 0; k < n; k++) begin
                e.port = order[k];
                if (order[k] == 1'b0) begin
                    if (!v.rw0) exp_rd0 = memf(v.a0);
                    e.rdata = exp_rd0;
                end else begin
                    if (!v.rw1) exp_rd1 = memf(v.a1);
                    e.rdata = exp_rd1;
                end
                sb.push_back(e);
            end
            bus.p0_strobe = v.en0; bus.p0_rw = v.rw0; bus.p0_addr = v.a0; bus.p0_wdata = v.d0;
            bus.p1_strobe = v.en1; bus.p1_rw = v.rw1; bus.p1_addr = v.a1; bus.p1_wdata = v.d1;
            issued = 0;
            served = 0;
            for (int c = 0; c < 40 && served < n; c++) begin
                tick();
                chk1("vec_dual_ready", bus.p0_ready & bus.p1_ready, 1'b0);
                if (bus.m_strobe) begin
                    p = (issued < n) ? order[issued] : 1'b0;
                    chk1("vec_grant", bus.grant, p);
                    chk("vec_m_addr", 64'(bus.m_addr), 64'(p ? v.a1 : v.a0));
                    chk1("vec_m_rw", bus.m_rw, p ? v.rw1 : v.rw0);
                    if (p ? v.rw1 : v.rw0) chk("vec_m_wdata", 64'(bus.m_wdata), 64'(p ? v.d1 : v.d0));
                    issued++;
                end
                if (bus.p0_ready || bus.p1_ready) begin
                    p = bus.p1_ready;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL vec_sb_underflow: unexpected ready on port %0d", p);
                    end else begin
                        e = sb.pop_front();
                        chk1("vec_port", p, e.port);
                        chk("vec_rdata", 64'(p ? bus.p1_rdata : bus.p0_rdata), 64'(e.rdata));
                    end
                    if (p) bus.p1_strobe = 1'b0;
                    else   bus.p0_strobe = 1'b0;
                    served++;
                end
            end
            chk("vec_served", 64'(served), 64'(n));
            sb.delete();
            bus.p0_strobe = 1'b0;
            bus.p1_strobe = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
